// File: rtl/puf_majority_voter.sv
// ---------------------------------------------------------------------------
// puf_majority_voter
//
// Purpose:
//    Temporal majority voter placed between the RO PUF core and the error
//    correction stage. Each request evaluates the PUF VOTES times on the same
//    challenge, counts the ones seen on every response bit, and then emits a
//    majority-voted WIDTH-bit response together with a one-cycle done pulse.
//    A per-evaluation watchdog aborts the request if the PUF never answers.
//
// Ports:
//    clk            system clock (10 MHz domain)
//    reset          synchronous, active-high reset
//    start          request pulse, accepted only while idle
//    challenge_in   challenge, latched when start is accepted
//    puf_start      one-cycle launch pulse to the PUF
//    puf_challenge  latched challenge, stable for the whole request
//    puf_response   raw PUF response, valid while puf_done=1
//    puf_done       PUF completion pulse
//    response       registered majority-voted response
//    done           one-cycle pulse when response is updated
//    busy           high in every state except IDLE
//    timeout        one-cycle pulse when a PUF evaluation timed out
//
// Optional build macro:
//    PUF_MAJORITY_STABILITY_EN adds unstable_mask (bits that did not vote
//    unanimously) and unstable_count (popcount of that mask), both updated
//    together with response.
// ---------------------------------------------------------------------------
module puf_majority_voter #(
   parameter int WIDTH   = 256,
   parameter int VOTES   = 7,
   parameter int CNT_W   = 4,
   parameter int TIMEOUT = 1000000,
   parameter int TO_W    = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [7:0]       challenge_in,
   output logic             puf_start,
   output logic [7:0]       puf_challenge,
   input  logic [WIDTH-1:0] puf_response,
   input  logic             puf_done,
   output logic [WIDTH-1:0] response,
   output logic             done,
   output logic             busy,
   output logic             timeout
`ifdef PUF_MAJORITY_STABILITY_EN
   ,
   output logic [WIDTH-1:0] unstable_mask,
   output logic [8:0]       unstable_count
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT,
      FINISH
   } state_t;

   localparam logic [CNT_W-1:0] HALF_VOTES  = CNT_W'(VOTES / 2);
   localparam logic [3:0]       LAST_ROUND  = 4'(VOTES - 1);
   localparam logic [TO_W-1:0]  TIMER_LIMIT = TO_W'(TIMEOUT - 1);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt [WIDTH];
   logic [3:0]       round;
   logic [TO_W-1:0]  timer;
   logic [TO_W-1:0]  timer_inc;
   logic             timer_expired;
   logic             last_round;

   // The watchdog fires when the incremented timer would reach TIMEOUT-1, so
   // timeout appears exactly TIMEOUT cycles after the launch pulse.
   assign timer_inc     = timer + TO_W'(1);
   assign timer_expired = (timer_inc == TIMER_LIMIT);
   assign last_round    = (round == LAST_ROUND);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic plus the state-decoded outputs. A puf_done arriving in
   // the same cycle the watchdog expires takes priority, so the vote counts.
   always_comb begin
      state_next = state;
      puf_start  = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_next = LAUNCH;
            end
         end
         LAUNCH: begin
            puf_start  = 1'b1;
            state_next = WAIT;
         end
         WAIT: begin
            if (puf_done) begin
               state_next = last_round ? FINISH : LAUNCH;
            end else if (timer_expired) begin
               state_next = IDLE;
            end
         end
         FINISH: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

`ifdef PUF_MAJORITY_STABILITY_EN
   logic [WIDTH-1:0] mask_next;
   logic [8:0]       count_next;

   // A bit is unstable when it was seen both as 0 and as 1 during the request.
   always_comb begin
      mask_next  = '0;
      count_next = '0;
      for (int i = 0; i < WIDTH; i++) begin
         mask_next[i] = (cnt[i] != '0) && (cnt[i] != CNT_W'(VOTES));
         count_next   = count_next + 9'(mask_next[i]);
      end
   end
`endif

   // Datapath: challenge latch, per-bit vote counters, round and watchdog
   // counters, and the registered result/pulse outputs. done and timeout
   // default low so they can only ever be single-cycle pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         puf_challenge <= '0;
         round         <= '0;
         timer         <= '0;
         response      <= '0;
         done          <= 1'b0;
         timeout       <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
`ifdef PUF_MAJORITY_STABILITY_EN
         unstable_mask  <= '0;
         unstable_count <= '0;
`endif
      end else begin
         done    <= 1'b0;
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  puf_challenge <= challenge_in;
                  round         <= '0;
                  for (int i = 0; i < WIDTH; i++) begin
                     cnt[i] <= '0;
                  end
               end
            end
            LAUNCH: begin
               timer <= '0;
            end
            WAIT: begin
               if (puf_done) begin
                  round <= round + 4'd1;
                  for (int i = 0; i < WIDTH; i++) begin
                     cnt[i] <= cnt[i] + CNT_W'(puf_response[i]);
                  end
               end else if (timer_expired) begin
                  timeout <= 1'b1;
               end else begin
                  timer <= timer_inc;
               end
            end
            FINISH: begin
               done <= 1'b1;
               for (int i = 0; i < WIDTH; i++) begin
                  response[i] <= (cnt[i] > HALF_VOTES);
               end
`ifdef PUF_MAJORITY_STABILITY_EN
               unstable_mask  <= mask_next;
               unstable_count <= count_next;
`endif
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_puf_majority_voter.sv
// ---------------------------------------------------------------------------
// tb_puf_majority_voter
//
// Purpose:
//    Directed bench for puf_majority_voter (WIDTH=256, VOTES=7, TIMEOUT=100).
//    A negedge-driven PUF model answers each launch 50 cycles later using a
//    per-run response table, and also tallies launches, done/timeout pulses
//    and challenge stability. The directed sequence lives in one initial
//    block. Build with PUF_MAJORITY_STABILITY_EN to also cover the stability
//    outputs.
// ---------------------------------------------------------------------------
module tb_puf_majority_voter;

   localparam int WIDTH = 256;

   logic             clk;
   logic             reset;
   logic             start;
   logic [7:0]       challenge_in;
   logic             puf_start;
   logic [7:0]       puf_challenge;
   logic [WIDTH-1:0] puf_response;
   logic             puf_done;
   logic [WIDTH-1:0] response;
   logic             done;
   logic             busy;
   logic             timeout;
`ifdef PUF_MAJORITY_STABILITY_EN
   logic [WIDTH-1:0] unstable_mask;
   logic [8:0]       unstable_count;
`endif

   // Bench bookkeeping shared between the model and the directed sequence.
   int               checks_total  = 0;
   int               checks_passed = 0;
   int               cyc           = 0;
   int               launches      = 0;
   int               dones         = 0;
   int               timeouts      = 0;
   int               chal_err      = 0;
   int               run_base      = 0;
   int               launch_cyc    = 0;
   int               done_cyc      = 0;
   int               timeout_cyc   = 0;
   int               last_pd_cyc   = 0;
   int               pending       = 0;
   int               delay_left    = 0;
   int               resp_idx      = 0;
   int               idx           = 0;
   logic             puf_answer    = 1'b1;
   logic             inject_done   = 1'b0;
   logic [7:0]       exp_chal      = 8'h00;
   logic [WIDTH-1:0] resp_tab [7];

   puf_majority_voter #(
      .WIDTH   (WIDTH),
      .VOTES   (7),
      .CNT_W   (4),
      .TIMEOUT (100),
      .TO_W    (20)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .challenge_in  (challenge_in),
      .puf_start     (puf_start),
      .puf_challenge (puf_challenge),
      .puf_response  (puf_response),
      .puf_done      (puf_done),
      .response      (response),
      .done          (done),
      .busy          (busy),
      .timeout       (timeout)
`ifdef PUF_MAJORITY_STABILITY_EN
      ,
      .unstable_mask  (unstable_mask),
      .unstable_count (unstable_count)
`endif
   );

   // 10 ns clock period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // PUF model and event monitor, evaluated on the inactive edge. A launch
   // seen in cycle L is answered with puf_done high in cycle L+50 unless
   // reset intervenes or answering is disabled.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (done) begin
         dones    = dones + 1;
         done_cyc = cyc;
      end
      if (timeout) begin
         timeouts    = timeouts + 1;
         timeout_cyc = cyc;
      end
      if (busy && (puf_challenge !== exp_chal)) begin
         chal_err = chal_err + 1;
      end
      puf_done = inject_done;
      if (reset) begin
         pending = 0;
      end else if (pending != 0) begin
         if (delay_left == 1) begin
            puf_response = resp_tab[resp_idx];
            puf_done     = 1'b1;
            last_pd_cyc  = cyc;
            pending      = 0;
         end else begin
            delay_left = delay_left - 1;
         end
      end
      if (puf_start) begin
         launch_cyc = cyc;
         idx        = launches - run_base;
         launches   = launches + 1;
         if (puf_answer && !reset) begin
            pending    = 1;
            delay_left = 50;
            resp_idx   = (idx > 6) ? 6 : ((idx < 0) ? 0 : idx);
         end
      end
   end

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                              input logic [WIDTH-1:0] expected);
      checks_total = checks_total + 1;
      assert (observed === expected) checks_passed = checks_passed + 1;
      else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
   endtask

   // Issue one request with the given challenge.
   task automatic applyStimulus(input logic [7:0] chal);
      exp_chal = chal;
      run_base = launches;
      @(negedge clk);
      start        = 1'b1;
      challenge_in = chal;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Wait for the voter to return to idle within a cycle budget.
   task automatic waitIdle(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      @(negedge clk);
      checkOutput(tag, WIDTH'(busy), '0);
   endtask

   // Wait until a given number of launches of the current request occurred.
   task automatic waitLaunches(input string tag, input int count, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (launches - run_base >= count) break;
         @(negedge clk);
      end
      checkOutput(tag, WIDTH'(launches - run_base >= count), WIDTH'(1));
   endtask

   int d0;
   int t0;
   int l0;

   initial begin
      reset        = 1'b1;
      start        = 1'b1;
      challenge_in = 8'hFF;
      puf_response = '0;
      puf_done     = 1'b0;
      for (int i = 0; i < 7; i++) resp_tab[i] = '0;

      // Reset held three cycles while start is asserted.
      repeat (3) @(negedge clk);
      checkOutput("rst_response", response, '0);
      checkOutput("rst_busy", WIDTH'(busy), '0);
      checkOutput("rst_done", WIDTH'(done), '0);
      checkOutput("rst_timeout", WIDTH'(timeout), '0);
      checkOutput("rst_challenge", WIDTH'(puf_challenge), '0);
      checkOutput("rst_no_launch", WIDTH'(launches), '0);
      reset = 1'b0;
      start = 1'b0;
      repeat (2) @(negedge clk);

      // Constant A5 pattern on every run.
      for (int i = 0; i < 7; i++) resp_tab[i] = {32{8'hA5}};
      d0 = dones;
      t0 = timeouts;
      applyStimulus(8'h3C);
      waitIdle("a5_idle", 1000);
      checkOutput("a5_launches", WIDTH'(launches - run_base), WIDTH'(7));
      checkOutput("a5_challenge", WIDTH'(chal_err), '0);
      checkOutput("a5_response", response, {32{8'hA5}});
      checkOutput("a5_done_count", WIDTH'(dones - d0), WIDTH'(1));
      checkOutput("a5_done_latency", WIDTH'(done_cyc - last_pd_cyc), WIDTH'(2));
      checkOutput("a5_no_timeout", WIDTH'(timeouts - t0), '0);
`ifdef PUF_MAJORITY_STABILITY_EN
      checkOutput("a5_mask", unstable_mask, '0);
      checkOutput("a5_ucount", WIDTH'(unstable_count), '0);
`endif

      // bit0 set in runs 0,2,4,6 (4 of 7), bit1 set in runs 1,3,5 (3 of 7).
      for (int i = 0; i < 7; i++) resp_tab[i] = {254'b0, (i % 2 == 1), (i % 2 == 0)};
      d0 = dones;
      applyStimulus(8'h5A);
      waitIdle("maj_idle", 1000);
      checkOutput("maj_launches", WIDTH'(launches - run_base), WIDTH'(7));
      checkOutput("maj_response", response, 256'h1);
      checkOutput("maj_done_count", WIDTH'(dones - d0), WIDTH'(1));
`ifdef PUF_MAJORITY_STABILITY_EN
      checkOutput("maj_mask", unstable_mask, 256'h3);
      checkOutput("maj_ucount", WIDTH'(unstable_count), WIDTH'(2));
`endif

      // Stray puf_done while idle must be ignored.
      d0 = dones;
      l0 = launches;
      @(posedge clk);
      inject_done = 1'b1;
      @(posedge clk);
      inject_done = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("idle_pd_busy", WIDTH'(busy), '0);
      checkOutput("idle_pd_launch", WIDTH'(launches - l0), '0);
      checkOutput("idle_pd_done", WIDTH'(dones - d0), '0);
      checkOutput("idle_pd_response", response, 256'h1);

      // Second start during round 2 is ignored; same vote result expected.
      applyStimulus(8'hC3);
      waitLaunches("busy_start_reach", 3, 500);
      @(negedge clk);
      start        = 1'b1;
      challenge_in = 8'h77;
      @(negedge clk);
      start = 1'b0;
      waitIdle("busy_start_idle", 1000);
      checkOutput("busy_start_launches", WIDTH'(launches - run_base), WIDTH'(7));
      checkOutput("busy_start_challenge", WIDTH'(chal_err), '0);
      checkOutput("busy_start_response", response, 256'h1);
      checkOutput("busy_start_dones", WIDTH'(dones - d0), WIDTH'(1));
      repeat (10) @(negedge clk);
      checkOutput("busy_start_no_relaunch", WIDTH'(launches - run_base), WIDTH'(7));

      // PUF never answers: timeout 100 cycles after the single launch.
      puf_answer = 1'b0;
      d0 = dones;
      t0 = timeouts;
      applyStimulus(8'h11);
      waitIdle("to_idle", 400);
      checkOutput("to_count", WIDTH'(timeouts - t0), WIDTH'(1));
      checkOutput("to_latency", WIDTH'(timeout_cyc - launch_cyc), WIDTH'(100));
      checkOutput("to_launches", WIDTH'(launches - run_base), WIDTH'(1));
      checkOutput("to_response", response, 256'h1);
      checkOutput("to_no_done", WIDTH'(dones - d0), '0);
      puf_answer = 1'b1;

      // Reset while waiting in round 3 aborts silently.
      for (int i = 0; i < 7; i++) resp_tab[i] = {32{8'h0F}};
      d0 = dones;
      t0 = timeouts;
      applyStimulus(8'h99);
      waitLaunches("abort_reach", 4, 500);
      repeat (10) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      checkOutput("abort_busy", WIDTH'(busy), '0);
      checkOutput("abort_response", response, '0);
      l0 = launches;
      repeat (80) @(negedge clk);
      checkOutput("abort_no_launch", WIDTH'(launches - l0), '0);
      checkOutput("abort_no_done", WIDTH'(dones - d0), '0);
      checkOutput("abort_no_timeout", WIDTH'(timeouts - t0), '0);

      // Fresh request with all-ones responses.
      for (int i = 0; i < 7; i++) resp_tab[i] = '1;
      applyStimulus(8'hE7);
      waitIdle("ones_idle", 1000);
      checkOutput("ones_launches", WIDTH'(launches - run_base), WIDTH'(7));
      checkOutput("ones_response", response, '1);
      checkOutput("ones_dones", WIDTH'(dones - d0), WIDTH'(1));
      checkOutput("ones_challenge", WIDTH'(chal_err), '0);
`ifdef PUF_MAJORITY_STABILITY_EN
      checkOutput("ones_mask", unstable_mask, '0);
      checkOutput("ones_ucount", WIDTH'(unstable_count), '0);
`endif

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
